rp_8bit_timer: RTL and testbench
================================

Name: rp_8bit_timer

Overview:
- 8-bit timer/counter peripheral on the rp_8bit I/O bus.
- Directly downstream of the CPU I/O port: it decodes io_wen/io_ren/io_adr/io_wdt/io_msk and returns io_rdt.
- Upstream of the CPU interrupt inputs: drives two irq_req bits and consumes the matching irq_ack bits.
- Functions: prescaled counter, output-compare with optional clear-on-compare (CTC), overflow and compare interrupt flags.

Parameters:
- BASE, 6'h2C, I/O base address; BASE[1:0] must be 2'b00; occupies BASE..BASE+3.
- PSW, 10, prescaler counter width; fixed by the 1024 divider.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- io_wen  input  1  I/O write enable
- io_ren  input  1  I/O read enable
- io_adr  input  6  I/O address
- io_wdt  input  8  I/O write data
- io_msk  input  8  I/O write bit mask (1 = bit written)
- io_rdt  output  8  I/O read data, registered
- irq_req  output  2  [0] overflow request, [1] compare-match request
- irq_ack  input  2  interrupt acknowledge, same bit order

Behaviour:
- Clock and reset: rst is asynchronous, active-high; clk is the clock.
- Reset values: all registers 0, prescaler 0, io_rdt 8'h00, irq_req 2'b00.
- Register map (offset from BASE):
  - 0 TCR: [2:0] CS, [3] CTC, [4] OVIE, [5] CMIE, [7:6] read as 0.
  - 1 TCNT: counter.
  - 2 OCR: compare value.
  - 3 TIFR: [0] OVF, [1] CMF, [7:2] read as 0.
- Hit: io_adr[5:2] == BASE[5:2].
- Writes to TCR/TCNT/OCR when io_wen and hit: reg <= io_wdt & io_msk | reg & ~io_msk.
- Writes to TIFR are write-1-to-clear: flag cleared where io_wdt & io_msk is 1. Writing 0 has no effect.
- Reads: one cycle latency.
  - Cycle after io_ren with hit, io_rdt = selected register value.
  - Otherwise io_rdt = 8'h00, so an OR-mux across peripherals works.
  - Read value reflects register state before any same-cycle write.
- Prescaler, CS decode:
  - 0 = stopped; 1 = /1; 2 = /8; 3 = /64; 4 = /256; 5 = /1024; 6, 7 = stopped.
  - While stopped, the prescaler is held at 0 and no ticks occur.
  - Running: the prescaler increments each clk. When it equals div-1, it emits a one-cycle tick and wraps to 0.
  - /1 ticks every cycle.
  - Any write that changes CS resets the prescaler to 0.
- Counter, on a tick:
  - match = (TCNT == OCR).
  - If CTC and match: TCNT <= 0, set CMF. OVF is not set, even when OCR = 8'hFF.
  - Else, if match: set CMF, TCNT <= TCNT + 1.
  - If TCNT == 8'hFF and not cleared by CTC: TCNT <= 0, set OVF.
- TCNT write in the same cycle as a tick: the write wins. No increment and no match/overflow evaluation for that tick.
- Flag clear sources: TIFR W1C write, or irq_ack[0] for OVF and irq_ack[1] for CMF.
  - A set and a clear in the same cycle: set wins.
- irq_req[0] = OVF & OVIE; irq_req[1] = CMF & CMIE. Both are combinational from registers and remain level until the flag clears.
- Disabling an enable masks the request but does not clear the flag.
- Reset asserted mid-count returns everything to reset values immediately. The first tick after release occurs div cycles after CS is written nonzero.

Test Plan:
- Reset, then read BASE..BASE+3 -> io_rdt = 00,00,00,00 one cycle after each io_ren. irq_req = 0. A non-hit read gives io_rdt = 00.
- OCR=05, TCR=0x21 (CS=1, CMIE) -> TCNT increments every cycle. CMF sets on the tick where TCNT==05 and irq_req[1]=1 the next cycle. TCNT continues to 06.
- TCR=0x0A (CTC, /8), OCR=03 -> TCNT sequence 0,1,2,3,0, each value held 8 cycles. CMF set, OVF never set.
- TCNT=FE, TCR=0x11 (/1, OVIE) -> after 2 ticks TCNT=00, OVF=1, irq_req[0]=1. Pulse irq_ack[0] -> OVF=0 and irq_req[0]=0 next cycle.
- TIFR=03, write TIFR with io_wdt=FF, io_msk=01 -> OVF cleared, CMF stays set. Write TCR with io_wdt=00, io_msk=08 -> only the CTC bit changes.
- Overflow tick coinciding with irq_ack[0]=1 -> OVF stays 1. TCNT write coinciding with a tick -> TCNT = written value, no flag change.

Source files
------------

// File: rtl/rp_8bit_timer_if.sv
// rp_8bit_timer_if: rp_8bit I/O bus and interrupt lines as seen by one peripheral.
//   io_wen   CPU -> periph  write strobe (single cycle, no handshake)
//   io_ren   CPU -> periph  read strobe; data appears on io_rdt next cycle
//   io_adr   CPU -> periph  6-bit I/O address
//   io_wdt   CPU -> periph  write data
//   io_msk   CPU -> periph  write bit mask, 1 = bit written
//   io_rdt   periph -> CPU  registered read data, 8'h00 when not selected
//   irq_req  periph -> CPU  level interrupt requests, [0] overflow, [1] compare
//   irq_ack  CPU -> periph  single-cycle acknowledge, same bit order
// Handshake: there is no valid/ready pair. A strobe is taken on every clk edge
// where it is high; a read returns data exactly one cycle later, and irq_req
// stays high until the peripheral sees an ack or a flag-clear write.
interface rp_8bit_timer_if;
  logic       io_wen;
  logic       io_ren;
  logic [5:0] io_adr;
  logic [7:0] io_wdt;
  logic [7:0] io_msk;
  logic [7:0] io_rdt;
  logic [1:0] irq_req;
  logic [1:0] irq_ack;

  modport master (
    output io_wen, io_ren, io_adr, io_wdt, io_msk, irq_ack,
    input  io_rdt, irq_req
  );

  modport slave (
    input  io_wen, io_ren, io_adr, io_wdt, io_msk, irq_ack,
    output io_rdt, irq_req
  );
endinterface

// File: rtl/rp_8bit_timer.sv
// rp_8bit_timer: 8-bit timer/counter on the rp_8bit I/O bus.
//   clk   clock
//   rst   asynchronous, active-high reset
//   bus   rp_8bit_timer_if.slave (I/O decode, read data, irq req/ack)
// Register map from BASE: 0 TCR {CMIE,OVIE,CTC,CS[2:0]}, 1 TCNT, 2 OCR,
// 3 TIFR {CMF,OVF} (write-1-to-clear).
module rp_8bit_timer #(
  parameter logic [5:0] BASE = 6'h2C,
  parameter int         PSW  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  rp_8bit_timer_if.slave       bus
);

  logic [5:0]     tcr_q, tcr_d;
  logic [7:0]     tcnt_q, tcnt_d;
  logic [7:0]     ocr_q, ocr_d;
  logic           ovf_q, ovf_d;
  logic           cmf_q, cmf_d;
  logic [PSW-1:0] presc_q, presc_d;
  logic [7:0]     rdt_q, rdt_d;

  logic           hit;
  logic           wr_tcr, wr_tcnt, wr_ocr, wr_tifr;
  logic [7:0]     wmask;
  logic           running;
  logic [PSW-1:0] presc_top;
  logic           tick;
  logic           match;
  logic           set_ovf, set_cmf;
  logic [1:0]     clr;

  always_comb begin
    hit     = (bus.io_adr[5:2] == BASE[5:2]);
    wr_tcr  = bus.io_wen && hit && (bus.io_adr[1:0] == 2'd0);
    wr_tcnt = bus.io_wen && hit && (bus.io_adr[1:0] == 2'd1);
    wr_ocr  = bus.io_wen && hit && (bus.io_adr[1:0] == 2'd2);
    wr_tifr = bus.io_wen && hit && (bus.io_adr[1:0] == 2'd3);
    wmask   = bus.io_wdt & bus.io_msk;

    tcr_d = tcr_q;
    if (wr_tcr) tcr_d = wmask[5:0] | (tcr_q & ~bus.io_msk[5:0]);
    ocr_d = ocr_q;
    if (wr_ocr) ocr_d = wmask | (ocr_q & ~bus.io_msk);

    // Prescaler terminal count (div-1) for the current clock select.
    running   = 1'b1;
    presc_top = '0;
    case (tcr_q[2:0])
      3'd1:    presc_top = PSW'(0);
      3'd2:    presc_top = PSW'(7);
      3'd3:    presc_top = PSW'(63);
      3'd4:    presc_top = PSW'(255);
      3'd5:    presc_top = PSW'(1023);
      default: running   = 1'b0;
    endcase
    tick = running && (presc_q == presc_top);

    // A CS change restarts the divider so the first tick lands div cycles later.
    if ((tcr_d[2:0] != tcr_q[2:0]) || !running || tick) presc_d = '0;
    else                                                 presc_d = presc_q + 1'b1;

    // A TCNT write overrides the tick entirely, including flag evaluation.
    match   = (tcnt_q == ocr_q);
    set_ovf = 1'b0;
    set_cmf = 1'b0;
    tcnt_d  = tcnt_q;
    if (wr_tcnt) begin
      tcnt_d = wmask | (tcnt_q & ~bus.io_msk);
    end else if (tick) begin
      set_cmf = match;
      if (match && tcr_q[3]) begin
        tcnt_d = 8'h00;
      end else begin
        tcnt_d  = tcnt_q + 8'h01;
        set_ovf = (tcnt_q == 8'hFF);
      end
    end

    // Set beats clear when both happen in one cycle.
    clr = bus.irq_ack | (wr_tifr ? wmask[1:0] : 2'b00);
    ovf_d = set_ovf | (ovf_q & ~clr[0]);
    cmf_d = set_cmf | (cmf_q & ~clr[1]);

    // Read data comes from pre-write state; zero when not selected.
    rdt_d = 8'h00;
    if (bus.io_ren && hit) begin
      case (bus.io_adr[1:0])
        2'd0:    rdt_d = {2'b00, tcr_q};
        2'd1:    rdt_d = tcnt_q;
        2'd2:    rdt_d = ocr_q;
        default: rdt_d = {6'b000000, cmf_q, ovf_q};
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcr_q   <= '0;
      tcnt_q  <= '0;
      ocr_q   <= '0;
      ovf_q   <= 1'b0;
      cmf_q   <= 1'b0;
      presc_q <= '0;
      rdt_q   <= '0;
    end else begin
      tcr_q   <= tcr_d;
      tcnt_q  <= tcnt_d;
      ocr_q   <= ocr_d;
      ovf_q   <= ovf_d;
      cmf_q   <= cmf_d;
      presc_q <= presc_d;
      rdt_q   <= rdt_d;
    end
  end

  assign bus.io_rdt  = rdt_q;
  assign bus.irq_req = {cmf_q & tcr_q[5], ovf_q & tcr_q[4]};

endmodule

// File: tb/tb_rp_8bit_timer.sv
module tb_rp_8bit_timer;
  localparam logic [5:0] BASE = 6'h2C;
  localparam int W = 10;

  logic clk;
  logic rst;
  rp_8bit_timer_if bus();

  rp_8bit_timer #(.BASE(BASE), .PSW(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  logic pend;

  // ---------------- reference model ----------------
  // Ticks are derived from elapsed cycles since the last clock-select change.
  logic [5:0] m_tcr;
  logic [7:0] m_tcnt, m_ocr;
  bit         m_ovf, m_cmf;
  int         cyc, m_w;

  function automatic int div_of(input logic [2:0] cs);
    case (cs)
      3'd1: return 1;
      3'd2: return 8;
      3'd3: return 64;
      3'd4: return 256;
      3'd5: return 1024;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_tcr = 0; m_tcnt = 0; m_ocr = 0; m_ovf = 0; m_cmf = 0;
    cyc = 0; m_w = 0;
  endtask

  task automatic model_step(input bit wen, input bit ren, input logic [5:0] adr,
                            input logic [7:0] wdt, input logic [7:0] msk,
                            input logic [1:0] ack, output logic [7:0] rd);
    bit hit;
    int off, div, nxt;
    bit tick, s_ovf, s_cmf;
    logic [7:0] wm;
    logic [5:0] ntcr;
    hit = (adr[5:2] == BASE[5:2]);
    off = int'(adr[1:0]);
    wm  = wdt & msk;
    rd  = 8'h00;
    if (ren && hit) begin
      if (off == 0) rd = {2'b00, m_tcr};
      else if (off == 1) rd = m_tcnt;
      else if (off == 2) rd = m_ocr;
      else rd = {6'b0, m_cmf, m_ovf};
    end
    div  = div_of(m_tcr[2:0]);
    tick = (div != 0) && (cyc > m_w) && (((cyc - m_w) % div) == 0);
    s_ovf = 0; s_cmf = 0;
    if (wen && hit && off == 1) begin
      m_tcnt = wm | (m_tcnt & ~msk);
    end else if (tick) begin
      if (m_tcnt == m_ocr) s_cmf = 1;
      if (m_tcnt == m_ocr && m_tcr[3]) begin
        m_tcnt = 0;
      end else begin
        nxt = int'(m_tcnt) + 1;
        if (nxt == 256) begin nxt = 0; s_ovf = 1; end
        m_tcnt = nxt[7:0];
      end
    end
    if (wen && hit && off == 0) begin
      ntcr = wm[5:0] | (m_tcr & ~msk[5:0]);
      if (ntcr[2:0] != m_tcr[2:0]) m_w = cyc;
      m_tcr = ntcr;
    end
    if (wen && hit && off == 2) m_ocr = wm | (m_ocr & ~msk);
    if (ack[0] || (wen && hit && off == 3 && wm[0])) m_ovf = 0;
    if (ack[1] || (wen && hit && off == 3 && wm[1])) m_cmf = 0;
    if (s_ovf) m_ovf = 1;
    if (s_cmf) m_cmf = 1;
    cyc++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_cycle(input bit wen, input bit ren, input logic [5:0] adr,
                           input logic [7:0] wdt, input logic [7:0] msk,
                           input logic [1:0] ack);
    logic [7:0] rd;
    bus.io_wen = wen; bus.io_ren = ren; bus.io_adr = adr;
    bus.io_wdt = wdt; bus.io_msk = msk; bus.irq_ack = ack;
    model_step(wen, ren, adr, wdt, msk, ack, rd);
    if (ren) exp_q.push_back({m_cmf & m_tcr[5], m_ovf & m_tcr[4], rd});
    @(posedge clk);
    #1;
    bus.io_wen = 0; bus.io_ren = 0; bus.irq_ack = 0;
  endtask

  task automatic wr(input int off, input logic [7:0] d, input logic [7:0] m = 8'hFF);
    bus_cycle(1, 0, BASE + 6'(off), d, m, 2'b00);
  endtask

  task automatic rd(input int off);
    bus_cycle(0, 1, BASE + 6'(off), 8'h00, 8'h00, 2'b00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus_cycle(0, 0, 6'h00, 8'h00, 8'h00, 2'b00);
  endtask

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk or posedge rst) begin
    if (rst) pend <= 1'b0;
    else     pend <= bus.io_ren;
  end

  always @(negedge clk) begin
    if (pend && !rst) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL read_unexpected: got %h, expected no read", {bus.irq_req, bus.io_rdt});
      end else begin
        check("read {irq,rdt}", {bus.irq_req, bus.io_rdt}, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.io_wen = 0; bus.io_ren = 0; bus.io_adr = 0;
    bus.io_wdt = 0; bus.io_msk = 0; bus.irq_ack = 0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset irq/rdt", {bus.irq_req, bus.io_rdt}, 10'h000);
    rst = 1'b0;

    // reset values and a non-hit read
    for (int i = 0; i < 4; i++) rd(i);
    bus_cycle(0, 1, 6'h10, 8'h00, 8'h00, 2'b00);

    // compare match at /1 with CMIE
    wr(2, 8'h05);
    wr(0, 8'h21);
    for (int i = 0; i < 8; i++) begin rd(1); rd(3); end

    // CTC at /8, OCR = 3
    wr(0, 8'h00); wr(3, 8'hFF); wr(1, 8'h00); wr(2, 8'h03);
    wr(0, 8'h0A);
    for (int i = 0; i < 40; i++) begin rd(1); rd(3); end

    // overflow at /1, then ack
    wr(0, 8'h00); wr(3, 8'hFF); wr(1, 8'hFE);
    wr(0, 8'h11);
    rd(1); rd(3); rd(3);
    bus_cycle(0, 0, 6'h00, 8'h00, 8'h00, 2'b01);
    rd(3);

    // both flags, partial W1C, masked TCR write
    wr(0, 8'h00); wr(3, 8'hFF); wr(2, 8'hFF); wr(1, 8'hFD);
    wr(0, 8'h01);
    idle(2);
    wr(0, 8'h00);
    rd(3);
    wr(3, 8'hFF, 8'h01);
    rd(3);
    wr(0, 8'h38);
    wr(0, 8'h00, 8'h08);
    rd(0);

    // overflow tick coinciding with ack; TCNT write coinciding with a tick
    wr(3, 8'hFF); wr(2, 8'h80);
    wr(0, 8'h11);
    wr(1, 8'hFE);
    idle(1);
    bus_cycle(0, 0, 6'h00, 8'h00, 8'h00, 2'b01);
    rd(3);
    wr(1, 8'h40);
    rd(1); rd(3);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit wen, ren;
      logic [5:0] adr;
      logic [7:0] d, m;
      logic [1:0] ack;
      wen = ($urandom_range(0, 9) < 3);
      ren = ($urandom_range(0, 9) < 5);
      adr = ($urandom_range(0, 9) < 9) ? BASE + 6'($urandom_range(0, 3)) : 6'($urandom);
      d   = 8'($urandom);
      m   = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
      // keep clock selects mostly fast so the counter moves
      if (adr == BASE && $urandom_range(0, 3) != 0) d[2:0] = 3'($urandom_range(1, 3));
      ack = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
      bus_cycle(wen, ren, adr, d, m, ack);
    end

    // reset mid-count, then first-tick timing at /8
    wr(0, 8'h3A);
    idle(2);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check("mid-reset irq/rdt", {bus.irq_req, bus.io_rdt}, 10'h000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) rd(i);
    wr(0, 8'h02);
    for (int i = 0; i < 20; i++) rd(1);

    idle(2);
    check("queue drained", W'(exp_q.size()), W'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
